// File: rtl/regfile_commit_checker.sv
// Run-time writeback checker: mirrors commits into a shadow register file, checks them
// against an expected-commit FIFO, then sweeps the shadow file against a golden file.
module regfile_commit_checker #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 1000,
  parameter int STREAM  = 1,
  localparam int RW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            gold_we,
  input  logic [RW-1:0]   gold_idx,
  input  logic [XLEN-1:0] gold_data,
  input  logic            exp_valid,
  output logic            exp_ready,
  input  logic [RW-1:0]   exp_rd,
  input  logic [XLEN-1:0] exp_data,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            check_all,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [15:0]     err_count,
  output logic [RW-1:0]   first_err_idx,
  output logic [XLEN-1:0] first_err_dut,
  output logic [XLEN-1:0] first_err_exp
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SWEEP, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [NREG-1:0][XLEN-1:0]  shadow_q, shadow_d;
  logic [NREG-1:0][XLEN-1:0]  gold_q, gold_d;
  logic [DEPTH-1:0][RW-1:0]   fifo_rd_q, fifo_rd_d;
  logic [DEPTH-1:0][XLEN-1:0] fifo_data_q, fifo_data_d;
  logic [AW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [TW-1:0]              tcnt_q, tcnt_d;
  logic [RW-1:0]              sidx_q, sidx_d;
  logic [15:0]                err_q, err_d;
  logic                       seen_q, seen_d;
  logic                       timeout_q, timeout_d;
  logic                       pass_q, pass_d;
  logic [RW-1:0]              fe_idx_q, fe_idx_d;
  logic [XLEN-1:0]            fe_dut_q, fe_dut_d, fe_exp_q, fe_exp_d;

  logic            commit, chk_commit, fifo_empty, fifo_full, push, pop;
  logic            rec_vld;
  logic [RW-1:0]   rec_idx;
  logic [XLEN-1:0] rec_dut, rec_exp;
  logic [31:0]     err_inc, err_sum;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    gold_d      = gold_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    tcnt_d      = tcnt_q;
    sidx_d      = sidx_q;
    seen_d      = seen_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    fe_idx_d    = fe_idx_q;
    fe_dut_d    = fe_dut_q;
    fe_exp_d    = fe_exp_q;
    rec_vld     = 1'b0;
    rec_idx     = '0;
    rec_dut     = '0;
    rec_exp     = '0;
    err_inc     = '0;

    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CW'(DEPTH));
    exp_ready  = !fifo_full && (state_q == S_IDLE || state_q == S_RUN);
    commit     = (state_q == S_RUN) && wb_en;
    chk_commit = commit && (wb_rd != '0) && (STREAM != 0);
    push       = exp_valid && exp_ready;
    pop        = chk_commit && !fifo_empty;

    if (push) begin
      fifo_rd_d[wptr_q]   = exp_rd;
      fifo_data_d[wptr_q] = exp_data;
      wptr_d              = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    if (gold_we && (state_q == S_IDLE || state_q == S_DONE)) gold_d[gold_idx] = gold_data;
    // Entry 0 is never written, so it keeps reading as zero.
    if (commit && wb_rd != '0) shadow_d[wb_rd] = wb_data;

    // Empty-FIFO test uses registered occupancy: a same-cycle push is not visible.
    if (chk_commit) begin
      if (fifo_empty) begin
        err_inc = 32'd1;
        rec_vld = 1'b1;
        rec_idx = wb_rd;
        rec_dut = wb_data;
      end else if (fifo_rd_q[rptr_q] != wb_rd || fifo_data_q[rptr_q] != wb_data) begin
        err_inc = 32'd1;
        rec_vld = 1'b1;
        rec_idx = wb_rd;
        rec_dut = wb_data;
        rec_exp = fifo_data_q[rptr_q];
      end
    end

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        sidx_d = '0;
        tcnt_d = commit ? '0 : tcnt_q + TW'(1);
        if (!commit && tcnt_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_SWEEP;
        end
        if (check_all) state_d = S_SWEEP;
      end
      S_SWEEP: begin
        // Leftover expectations are charged in the first sweep cycle and take
        // first-error priority over the index-0 compare of that same cycle.
        if (sidx_q == '0 && !fifo_empty) begin
          err_inc = 32'(cnt_q);
          rec_vld = 1'b1;
          wptr_d  = '0;
          rptr_d  = '0;
          cnt_d   = '0;
        end
        if (shadow_q[sidx_q] != gold_q[sidx_q]) begin
          err_inc = err_inc + 32'd1;
          if (!rec_vld) begin
            rec_idx = sidx_q;
            rec_dut = shadow_q[sidx_q];
            rec_exp = gold_q[sidx_q];
          end
          rec_vld = 1'b1;
        end
        sidx_d = sidx_q + RW'(1);
        if (sidx_q == RW'(NREG - 1)) begin
          state_d = S_DONE;
          sidx_d  = '0;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    err_sum = 32'(err_q) + err_inc;
    err_d   = (err_sum > 32'h0000_FFFF) ? 16'hFFFF : err_sum[15:0];

    if (rec_vld && !seen_q) begin
      seen_d   = 1'b1;
      fe_idx_d = rec_idx;
      fe_dut_d = rec_dut;
      fe_exp_d = rec_exp;
    end
    if (state_q == S_SWEEP && state_d == S_DONE) pass_d = (err_d == '0) && !timeout_q;

    if (start) begin
      state_d   = S_RUN;
      shadow_d  = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      cnt_d     = '0;
      tcnt_d    = '0;
      sidx_d    = '0;
      err_d     = '0;
      seen_d    = 1'b0;
      timeout_d = 1'b0;
      pass_d    = 1'b0;
      fe_idx_d  = '0;
      fe_dut_d  = '0;
      fe_exp_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      gold_q      <= '0;
      fifo_rd_q   <= '0;
      fifo_data_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      sidx_q      <= '0;
      err_q       <= '0;
      seen_q      <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      fe_idx_q    <= '0;
      fe_dut_q    <= '0;
      fe_exp_q    <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      gold_q      <= gold_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      sidx_q      <= sidx_d;
      err_q       <= err_d;
      seen_q      <= seen_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      fe_idx_q    <= fe_idx_d;
      fe_dut_q    <= fe_dut_d;
      fe_exp_q    <= fe_exp_d;
    end
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_SWEEP);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;
  assign first_err_idx = fe_idx_q;
  assign first_err_dut = fe_dut_q;
  assign first_err_exp = fe_exp_q;

endmodule

// File: tb/tb_regfile_commit_checker.sv
// Directed bench for regfile_commit_checker with hand-computed expectations.
module tb_regfile_commit_checker;
  localparam int XLEN = 32, NREG = 32, DEPTH = 8, TIMEOUT = 20, RW = 5;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            start = 1'b0, gold_we = 1'b0, exp_valid = 1'b0, wb_en = 1'b0, check_all = 1'b0;
  logic [RW-1:0]   gold_idx = '0, exp_rd = '0, wb_rd = '0;
  logic [XLEN-1:0] gold_data = '0, exp_data = '0, wb_data = '0;
  logic            exp_ready, busy, done, pass, timeout;
  logic [15:0]     err_count;
  logic [RW-1:0]   first_err_idx;
  logic [XLEN-1:0] first_err_dut, first_err_exp;

  int n_chk = 0, n_fail = 0, n = 0;

  regfile_commit_checker #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STREAM(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gold_we(gold_we), .gold_idx(gold_idx), .gold_data(gold_data),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_rd(exp_rd), .exp_data(exp_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .check_all(check_all),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_dut(first_err_dut), .first_err_exp(first_err_exp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_check_all();
    check_all = 1'b1; cyc(); check_all = 1'b0;
  endtask

  task automatic push(input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
    exp_valid = 1'b1; exp_rd = rd; exp_data = d; cyc(); exp_valid = 1'b0;
  endtask

  task automatic commit(input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
    wb_en = 1'b1; wb_rd = rd; wb_data = d; cyc(); wb_en = 1'b0;
  endtask

  task automatic load_gold(input logic [RW-1:0] idx, input logic [XLEN-1:0] d);
    gold_we = 1'b1; gold_idx = idx; gold_data = d; cyc(); gold_we = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 200) begin cyc(); cnt++; end
    check("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_exp_ready", 32'(exp_ready), 32'd1);
    check("rst_fe_idx", 32'(first_err_idx), 32'd0);
    check("rst_fe_dut", first_err_dut, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Clean run
    load_gold(5'd1, 32'd5);
    load_gold(5'd2, 32'd7);
    do_start();
    check("clean_busy", 32'(busy), 32'd1);
    push(5'd1, 32'd5);
    push(5'd2, 32'd7);
    commit(5'd1, 32'd5);
    commit(5'd2, 32'd7);
    check("clean_stream_err", 32'(err_count), 32'd0);
    do_check_all();
    wait_done(n);
    check("clean_sweep_cycles", 32'(n), 32'd32);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err", 32'(err_count), 32'd0);
    check("clean_busy_done", 32'(busy), 32'd0);

    // Data mismatch
    load_gold(5'd1, 32'd0);
    load_gold(5'd2, 32'd0);
    load_gold(5'd3, 32'h10);
    do_start();
    push(5'd3, 32'h10);
    commit(5'd3, 32'h11);
    check("mm_stream_err", 32'(err_count), 32'd1);
    check("mm_fe_idx", 32'(first_err_idx), 32'd3);
    check("mm_fe_dut", first_err_dut, 32'h11);
    check("mm_fe_exp", first_err_exp, 32'h10);
    do_check_all();
    wait_done(n);
    check("mm_total_err", 32'(err_count), 32'd2);
    check("mm_pass", 32'(pass), 32'd0);
    check("mm_fe_idx_kept", 32'(first_err_idx), 32'd3);

    // x0 commit ignored, unexpected commit counted
    load_gold(5'd3, 32'd0);
    do_start();
    commit(5'd0, 32'hFF);
    check("x0_err", 32'(err_count), 32'd0);
    commit(5'd4, 32'd1);
    check("unexp_err", 32'(err_count), 32'd1);
    check("unexp_fe_idx", 32'(first_err_idx), 32'd4);
    check("unexp_fe_dut", first_err_dut, 32'd1);
    check("unexp_fe_exp", first_err_exp, 32'd0);
    do_check_all();
    wait_done(n);
    check("unexp_total_err", 32'(err_count), 32'd2);

    // FIFO full and leftover expectations
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      check("fifo_ready_before_full", 32'(exp_ready), 32'd1);
      push(RW'(i + 1), 32'(i + 100));
    end
    check("fifo_full_ready", 32'(exp_ready), 32'd0);
    do_check_all();
    check("sweep_ready", 32'(exp_ready), 32'd0);
    wait_done(n);
    check("leftover_err", 32'(err_count), 32'(DEPTH));
    check("leftover_fe_idx", 32'(first_err_idx), 32'd0);
    check("leftover_fe_exp", first_err_exp, 32'd0);

    // Timeout
    do_start();
    n = 0;
    while (!timeout && n < 100) begin cyc(); n++; end
    check("timeout_set", 32'(timeout), 32'd1);
    check("timeout_cycles", 32'(n), 32'(TIMEOUT));
    wait_done(n);
    check("timeout_pass", 32'(pass), 32'd0);
    check("timeout_err", 32'(err_count), 32'd0);
    check("timeout_sticky", 32'(timeout), 32'd1);

    // Restart mid-RUN
    do_start();
    commit(5'd5, 32'd1);
    check("restart_pre_err", 32'(err_count), 32'd1);
    do_start();
    check("restart_err", 32'(err_count), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_fe_dut", first_err_dut, 32'd0);
    check("restart_timeout", 32'(timeout), 32'd0);

    // Reset mid-SWEEP
    commit(5'd5, 32'd1);
    do_check_all();
    repeat (3) cyc();
    check("sweep_busy", 32'(busy), 32'd1);
    check("sweep_err_nonzero", 32'(err_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_err", 32'(err_count), 32'd0);
    check("rst2_exp_ready", 32'(exp_ready), 32'd1);
    check("rst2_done", 32'(done), 32'd0);
    check("rst2_fe_idx", 32'(first_err_idx), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
